// File: rtl/multi_slew_limit.sv
// multi_slew_limit: CH signed channels share one 2-stage pipeline.
// Stage 1 clamps each sample to +/-mag_max; stage 2 limits the step against
// that channel's previous output. A clear pulse drains the pipeline, then
// zeroes the channel history one entry per cycle.
// Build option: define MULTI_SLEW_LIMIT_SLEW_EN to include the stage-2 slew
// limiter and per-channel history. Without it stage 2 is a plain register,
// and the clear sweep keeps its CH-cycle length so handshake timing is unchanged.
module multi_slew_limit #(
    parameter int WIDTH = 32,
    parameter int CH    = 4,
    parameter int CHW   = 2,
    parameter int CNTW  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic [CHW-1:0]          in_ch,
    input  logic signed [WIDTH-1:0] datain,
    output logic                    in_ready,
    input  logic [WIDTH-2:0]        mag_max,
    input  logic [WIDTH-2:0]        step_max,
    output logic                    out_valid,
    output logic [CHW-1:0]          out_ch,
    output logic signed [WIDTH-1:0] dataout,
    output logic                    sat_mag,
    output logic                    sat_step,
    output logic [CNTW-1:0]         sat_count
);
    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    localparam logic [CHW:0]   CH_LIM  = (CHW+1)'(CH);
    localparam logic [CHW-1:0] LAST_CH = CHW'(CH - 1);

    state_t                  state_reg;
    logic                    in_ready_reg;
    logic [CHW-1:0]          clr_idx_reg;

    logic                    s1_valid_reg;
    logic [CHW-1:0]          s1_ch_reg;
    logic signed [WIDTH-1:0] s1_data_reg;
    logic                    s1_mag_reg;
    logic                    s1_en_reg;

    logic                    out_valid_reg;
    logic [CHW-1:0]          out_ch_reg;
    logic signed [WIDTH-1:0] dataout_reg;
    logic                    sat_mag_reg;
    logic                    sat_step_reg;
    logic [CNTW-1:0]         sat_count_reg;

    logic                    accept;
    logic signed [WIDTH-1:0] mag_pos;
    logic signed [WIDTH-1:0] mag_neg;
    logic signed [WIDTH-1:0] clamp_next;
    logic                    mag_hit_next;
    logic signed [WIDTH-1:0] s2_data_next;
    logic                    s2_step_next;

    // Out-of-range channels are taken off the bus but never enter the pipeline.
    assign accept = in_valid && in_ready_reg && ({1'b0, in_ch} < CH_LIM);

    // Stage 1 combinational: symmetric magnitude clamp (bypassed when disabled).
    always_comb begin
        mag_pos      = $signed({1'b0, mag_max});
        mag_neg      = -mag_pos;
        clamp_next   = datain;
        mag_hit_next = 1'b0;
        if (enable && (datain > mag_pos)) begin
            clamp_next   = mag_pos;
            mag_hit_next = 1'b1;
        end else if (enable && (datain < mag_neg)) begin
            clamp_next   = mag_neg;
            mag_hit_next = 1'b1;
        end
    end

    // Stage 1 register: clamped sample plus the enable it was taken under.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_ch_reg    <= '0;
            s1_data_reg  <= '0;
            s1_mag_reg   <= 1'b0;
            s1_en_reg    <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_ch_reg   <= in_ch;
                s1_data_reg <= clamp_next;
                s1_mag_reg  <= mag_hit_next;
                s1_en_reg   <= enable;
            end
        end
    end

`ifdef MULTI_SLEW_LIMIT_SLEW_EN
    logic signed [WIDTH-1:0] prev_q [CH];
    logic signed [WIDTH-1:0] prev_sel;
    logic signed [WIDTH:0]   diff_ext;
    logic signed [WIDTH:0]   step_ext;
    logic signed [WIDTH:0]   up_ext;
    logic signed [WIDTH:0]   dn_ext;

    // Stage 2 combinational: step limit against the channel's last output.
    // Done one bit wider so c - prev cannot overflow; the chosen result lies
    // between prev and c, so truncating back to WIDTH is exact.
    always_comb begin
        prev_sel = '0;
        for (int i = 0; i < CH; i++) begin
            if (s1_ch_reg == CHW'(i)) begin
                prev_sel = prev_q[i];
            end
        end
        step_ext     = $signed({2'b00, step_max});
        diff_ext     = $signed({s1_data_reg[WIDTH-1], s1_data_reg}) - $signed({prev_sel[WIDTH-1], prev_sel});
        up_ext       = $signed({prev_sel[WIDTH-1], prev_sel}) + step_ext;
        dn_ext       = $signed({prev_sel[WIDTH-1], prev_sel}) - step_ext;
        s2_data_next = s1_data_reg;
        s2_step_next = 1'b0;
        if (s1_en_reg && (diff_ext > step_ext)) begin
            s2_data_next = up_ext[WIDTH-1:0];
            s2_step_next = 1'b1;
        end else if (s1_en_reg && (diff_ext < -step_ext)) begin
            s2_data_next = dn_ext[WIDTH-1:0];
            s2_step_next = 1'b1;
        end
    end

    // One history register per channel. It commits on the same edge that
    // raises out_valid, so a same-channel sample right behind reads it fresh.
    for (genvar gi = 0; gi < CH; gi++) begin : g_prev
        logic signed [WIDTH-1:0] prev_reg;

        // History update: new output, or zero during the clear sweep.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prev_reg <= '0;
            end else if (s1_valid_reg && (s1_ch_reg == CHW'(gi))) begin
                prev_reg <= s2_data_next;
            end else if ((state_reg == CLEAR) && (clr_idx_reg == CHW'(gi))) begin
                prev_reg <= '0;
            end
        end

        assign prev_q[gi] = prev_reg;
    end
`else
    logic unused_step;

    assign unused_step  = ^step_max;
    assign s2_data_next = s1_data_reg;
    assign s2_step_next = 1'b0;
`endif

    // Stage 2 register: drives the output port set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_ch_reg    <= '0;
            dataout_reg   <= '0;
            sat_mag_reg   <= 1'b0;
            sat_step_reg  <= 1'b0;
        end else begin
            out_valid_reg <= s1_valid_reg;
            out_ch_reg    <= s1_ch_reg;
            dataout_reg   <= s2_data_next;
            sat_mag_reg   <= s1_valid_reg && s1_mag_reg;
            sat_step_reg  <= s1_valid_reg && s2_step_next;
        end
    end

    // Saturating count of limited outputs; cleared as the FSM enters CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count_reg <= '0;
        end else if ((state_reg == DRAIN) && !s1_valid_reg) begin
            sat_count_reg <= '0;
        end else if (s1_valid_reg && (s1_mag_reg || s2_step_next) && (sat_count_reg != '1)) begin
            sat_count_reg <= sat_count_reg + 1'b1;
        end
    end

    // Clear sequencer. Stage 2 commits its history at the edge that registers
    // the output, so the pipeline is drained once stage 1 is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            in_ready_reg <= 1'b0;
            clr_idx_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (clear) begin
                        state_reg    <= DRAIN;
                        in_ready_reg <= 1'b0;
                    end else begin
                        in_ready_reg <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!s1_valid_reg) begin
                        state_reg   <= CLEAR;
                        clr_idx_reg <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_idx_reg == LAST_CH) begin
                        state_reg    <= IDLE;
                        in_ready_reg <= 1'b1;
                    end else begin
                        clr_idx_reg <= clr_idx_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    in_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_ch    = out_ch_reg;
    assign dataout   = dataout_reg;
    assign sat_mag   = sat_mag_reg;
    assign sat_step  = sat_step_reg;
    assign sat_count = sat_count_reg;

endmodule

// File: tb/tb_multi_slew_limit.sv
// Directed bench for multi_slew_limit. Expected outputs are hand-computed for
// both builds (with and without MULTI_SLEW_LIMIT_SLEW_EN); a negedge monitor
// matches each output against a queue of expectations, including latency.
module tb_multi_slew_limit;
`ifdef MULTI_SLEW_LIMIT_SLEW_EN
    localparam bit SLEW = 1'b1;
`else
    localparam bit SLEW = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic               clear;
    logic               in_valid;
    logic [2:0]         in_ch;
    logic signed [31:0] datain;
    logic               in_ready;
    logic [30:0]        mag_max;
    logic [30:0]        step_max;
    logic               out_valid;
    logic [2:0]         out_ch;
    logic signed [31:0] dataout;
    logic               sat_mag;
    logic               sat_step;
    logic [2:0]         sat_count;

    typedef struct {
        logic [2:0] ch;
        int         data;
        bit         mag;
        bit         step;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    multi_slew_limit #(.WIDTH(32), .CH(4), .CHW(3), .CNTW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ch     (in_ch),
        .datain    (datain),
        .in_ready  (in_ready),
        .mag_max   (mag_max),
        .step_max  (step_max),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .dataout   (dataout),
        .sat_mag   (sat_mag),
        .sat_step  (sat_step),
        .sat_count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one sample for one cycle and queue its expected output.
    task automatic push(input logic [2:0] ch, input int data, input int exp_s,
                        input int exp_n, input bit m, input bit st);
        exp_t e;
        in_valid = 1'b1;
        in_ch    = ch;
        datain   = data;
        e.ch     = ch;
        e.data   = SLEW ? exp_s : exp_n;
        e.mag    = m;
        e.step   = SLEW ? st : 1'b0;
        e.cyc    = cyc + 2;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Output monitor: one line per transaction, checked against the queue.
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                $display("out cyc=%0d ch=%0d data=%0d mag=%0b step=%0b cnt=%0d",
                         cyc, out_ch, dataout, sat_mag, sat_step, sat_count);
                check("latency", cyc, mon_e.cyc);
                check("out_ch", out_ch, mon_e.ch);
                check("dataout", dataout, mon_e.data);
                check("sat_mag", sat_mag, mon_e.mag);
                check("sat_step", sat_step, mon_e.step);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  low;
        bit  done;
        rst_n    = 1'b0;
        enable   = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_ch    = '0;
        datain   = '0;
        mag_max  = 31'd1000;
        step_max = 31'd100;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_dataout", dataout, 0);
        check("rst_sat_mag", sat_mag, 0);
        check("rst_sat_step", sat_step, 0);
        check("rst_sat_count", sat_count, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_ch", out_ch, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_idle", in_ready, 1);

        // 1: plain pass-through inside both limits
        push(3'd0, 50, 50, 50, 1'b0, 1'b0);
        idle(3);

        // 2: back-to-back same channel, clamped and slewed
        push(3'd0, 5000, 150, 1000, 1'b1, 1'b1);
        push(3'd0, 5000, 250, 1000, 1'b1, 1'b1);
        push(3'd0, 5000, 350, 1000, 1'b1, 1'b1);
        idle(3);
        check("cnt_t2", sat_count, 3);

        // 3: most negative input, unlimited slew
        step_max = '1;
        push(3'd1, 32'h8000_0000, -1000, -1000, 1'b1, 1'b0);
        idle(3);
        check("cnt_t3", sat_count, 4);

        // Out-of-range channel: accepted, no output, no history write
        in_valid = 1'b1;
        in_ch    = 3'd5;
        datain   = 5000;
        @(posedge clk);
        #1;
        idle(3);
        check("cnt_drop", sat_count, 4);
        step_max = 31'd100;
        push(3'd1, -1000, -1000, -1000, 1'b0, 1'b0);
        idle(3);

        // 4: interleaved independent channels
        step_max = 31'd300;
        push(3'd2, 500, 300, 500, 1'b0, 1'b1);
        push(3'd3, -500, -300, -500, 1'b0, 1'b1);
        push(3'd2, 500, 500, 500, 1'b0, 1'b0);
        push(3'd3, -500, -500, -500, 1'b0, 1'b0);
        idle(3);
        check("cnt_t4", sat_count, SLEW ? 6 : 4);

        // 5: bypass then re-enable; enable follows each sample
        step_max = 31'd100;
        enable   = 1'b0;
        push(3'd0, 9999, 9999, 9999, 1'b0, 1'b0);
        enable   = 1'b1;
        push(3'd0, 0, 9899, 0, 1'b0, 1'b1);
        idle(3);
        check("cnt_t5", sat_count, SLEW ? 7 : 4);

        // Counter saturates at all-ones
        push(3'd1, 5000, -900, 1000, 1'b1, 1'b1);
        push(3'd1, 5000, -800, 1000, 1'b1, 1'b1);
        push(3'd1, 5000, -700, 1000, 1'b1, 1'b1);
        push(3'd1, 5000, -600, 1000, 1'b1, 1'b1);
        idle(3);
        check("cnt_sat", sat_count, 7);

        // 6: clear with two samples in flight, clear on the second acceptance
        push(3'd0, 0, 9799, 0, 1'b0, 1'b1);
        clear = 1'b1;
        push(3'd1, 0, -500, 0, 1'b0, 1'b1);
        in_valid = 1'b0;
        clear    = 1'b0;
        low  = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
            end else begin
                low++;
                clear = (low == 4);
            end
        end
        clear = 1'b0;
        check("clr_done", done, 1);
        check("clr_ready_low", low, 6);
        check("cnt_clr", sat_count, 0);
        push(3'd0, 500, 100, 500, 1'b0, 1'b1);
        push(3'd3, 0, 0, 0, 1'b0, 1'b0);
        idle(3);
        check("cnt_after_clr", sat_count, SLEW ? 1 : 0);

        idle(3);
        check("pending", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_slew_limit.md
Name: multi_slew_limit

Overview:
- Parametrised successor to the single-channel delta clamp.
- Time-multiplexes CH signed channels, e.g. per-wheel motor commands, through one shared pipeline.
- Each sample gets two limits: a symmetric magnitude clamp, then a per-channel slew (step) limit against that channel's last output.
- Sits between the control-loop output and the PWM/driver stage. It has a status counter and a state-clear sequencer.

Parameters:
- WIDTH, 32, sample width, two's complement.
- CH, 4, number of channels.
- CHW, 2, channel index width; must satisfy 2^CHW >= CH.
- CNTW, 16, saturation counter width.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- enable  input  1  1 = apply limits; 0 = bypass.
- clear  input  1  single-cycle pulse; zeroes all channel history.
- in_valid  input  1  datain/in_ch valid.
- in_ch  input  CHW  channel of datain.
- datain  input  WIDTH  signed sample.
- in_ready  output  1  block accepts a sample this cycle.
- mag_max  input  WIDTH-1  unsigned magnitude limit.
- step_max  input  WIDTH-1  unsigned per-sample slew limit.
- out_valid  output  1  dataout valid; no backpressure.
- out_ch  output  CHW  channel of dataout.
- dataout  output  WIDTH  limited sample.
- sat_mag  output  1  magnitude clamp was applied to this output.
- sat_step  output  1  slew clamp was applied to this output.
- sat_count  output  CNTW  count of outputs with sat_mag or sat_step set.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, all prev[0..CH-1]=0, both pipeline stages empty, FSM=IDLE.
- Transfer: a sample is accepted when in_valid and in_ready are both 1. Samples with in_ch >= CH are accepted but dropped; they produce no output and no state write.
- Latency: exactly 2 cycles from acceptance to out_valid. Throughput is 1 sample per cycle, including back-to-back samples on the same channel.
- Stage 1 (magnitude clamp, signed compare):
  - datain > +mag_max gives c=+mag_max, sat_mag=1.
  - datain < -mag_max gives c=-mag_max, sat_mag=1.
  - Otherwise c=datain.
  - mag_max=0 forces c=0.
- Stage 2 (slew), computed in WIDTH+1 bits, d = c - prev[ch]:
  - d > step_max gives out = prev + step_max, sat_step=1.
  - d < -step_max gives out = prev - step_max, sat_step=1.
  - Otherwise out = c.
  - Result is always between prev and c, so no overflow.
  - prev[ch] <= out in the same cycle out_valid is asserted. The next same-channel sample in stage 2 sees the updated value, so no forwarding hazard.
- enable=0: dataout=datain at the same 2-cycle latency. sat_mag=sat_step=0. prev[ch] is still updated, so re-enabling does not jump.
- enable is sampled per sample, at stage 1, and carried down the pipeline.
- sat_count increments on each output with sat_mag|sat_step. It saturates at all-ones (no wrap) and clears on entry to CLEAR.
- FSM:
  - IDLE: in_ready=1. A clear pulse moves to DRAIN.
  - DRAIN: in_ready=0; no new samples accepted. In-flight samples complete normally. Moves to CLEAR when both stages are empty (at most 2 cycles).
  - CLEAR: in_ready=0. Writes prev[i]=0 for i=0..CH-1, one per cycle. Returns to IDLE after CH cycles.
- clear asserted outside IDLE is ignored.
- A clear on the same cycle as an accepted sample: the sample is accepted, and the FSM enters DRAIN next cycle.
- rst_n asserted mid-DRAIN or mid-CLEAR: immediate reset; in-flight outputs are lost.

Optional Feature:
- Macro: MULTI_SLEW_LIMIT_SLEW_EN.
- Defined: stage 2 slew limiting as above.
- Undefined:
  - Slew logic and prev storage are removed. Stage 2 is a plain register, so latency stays 2.
  - step_max is ignored and sat_step=0.
  - sat_count counts sat_mag only.
  - CLEAR still takes CH cycles, so handshake timing is identical.

Test Plan:
1. Reset, then enable=1, mag_max=1000, step_max=100; ch0 datain=50 -> 2 cycles later out_valid=1, dataout=50, no sat flags.
2. ch0 datain=5000 on three consecutive cycles -> outputs 150, 250, 350; sat_mag=1 and sat_step=1 on each; sat_count=3.
3. mag_max=1000, step_max=max; ch1 datain=-2^31 -> dataout=-1000, sat_mag=1, sat_step=0.
4. Interleave ch2 +500 and ch3 -500, each twice, step_max=300 -> ch2: 300, 500; ch3: -300, -500; channels independent.
5. enable=0, ch0 datain=9999 -> dataout=9999, flags 0. Then enable=1, ch0 datain=0, step_max=100 -> dataout=9899.
6. clear pulse with 2 samples in flight -> both outputs emitted, in_ready low for 2+CH cycles, sat_count=0. Then ch0 datain=500, step_max=100 -> dataout=100.
